// File: rtl/hazard_forward_unit_pkg.sv
// Shared types and helpers for the hazard/forwarding unit (see HAZARD_FWD_EN in the top).
package hazard_forward_unit_pkg;

  // Widest register index the slot structs can hold; REG_AW must not exceed it.
  localparam int REG_AW_MAX = 8;

  typedef logic [REG_AW_MAX-1:0] idx_t;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef struct packed {
    logic valid;
    idx_t rd;
    idx_t rs1;
    idx_t rs2;
    logic uses_rs2;
    logic regwrite;
    logic memread;
  } ex_slot_t;

  typedef struct packed {
    logic valid;
    idx_t rd;
    logic regwrite;
  } pipe_slot_t;

  // x0 is hard-wired, so a write to it never produces a dependency.
  function automatic logic writes_reg(input logic valid, input logic regwrite,
                                      input idx_t rd, input idx_t src);
    return valid && regwrite && (rd != '0) && (rd == src);
  endfunction

  function automatic logic reads_reg(input logic valid, input logic regwrite, input idx_t rd,
                                     input idx_t rs1, input idx_t rs2, input logic uses_rs2);
    return writes_reg(valid, regwrite, rd, rs1) ||
           (uses_rs2 && writes_reg(valid, regwrite, rd, rs2));
  endfunction

endpackage

// File: rtl/hazard_forward_unit_fwd_compare.sv
// Maps one EX source index against the MEM and WB slots to an operand select.
module fwd_compare
  import hazard_forward_unit_pkg::*;
(
  input  idx_t       src,
  input  pipe_slot_t mem_slot,
  input  pipe_slot_t wb_slot,
  output fwd_sel_t   sel
);

  // MEM holds the younger result, so it is checked first.
  always_comb begin
    if (writes_reg(mem_slot.valid, mem_slot.regwrite, mem_slot.rd, src))
      sel = FWD_MEM;
    else if (writes_reg(wb_slot.valid, wb_slot.regwrite, wb_slot.rd, src))
      sel = FWD_WB;
    else
      sel = FWD_RF;
  end

endmodule

// File: rtl/hazard_forward_unit.sv
// Hazard detection and operand forwarding for a 5-stage pipeline.
// HAZARD_FWD_EN defined: forwarding plus 1-cycle load-use stall; undefined: interlock-only.
module hazard_forward_unit
  import hazard_forward_unit_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              id_uses_rs2,
  input  logic              flush,
  output logic [1:0]        forwardA,
  output logic [1:0]        forwardB,
  output logic              stall,
  output logic [CNT_W-1:0]  stall_count
);

  ex_slot_t   ex_q, ex_d;
  pipe_slot_t mem_q, wb_q;
  idx_t       rs1_idx, rs2_idx;

  assign rs1_idx = idx_t'(id_rs1);
  assign rs2_idx = idx_t'(id_rs2);

`ifdef HAZARD_FWD_EN
  fwd_sel_t fwd_a, fwd_b;

  fwd_compare u_cmp_a (.src(ex_q.rs1), .mem_slot(mem_q), .wb_slot(wb_q), .sel(fwd_a));
  fwd_compare u_cmp_b (.src(ex_q.rs2), .mem_slot(mem_q), .wb_slot(wb_q), .sel(fwd_b));

  assign forwardA = fwd_a;
  assign forwardB = ex_q.uses_rs2 ? fwd_b : FWD_RF;

  // A load's data is not ready until MEM ends, so a dependent decode waits one cycle.
  assign stall = id_valid && !flush &&
                 reads_reg(ex_q.valid, ex_q.memread, ex_q.rd, rs1_idx, rs2_idx, id_uses_rs2);
`else
  logic unused_ex_fields;

  assign forwardA = FWD_RF;
  assign forwardB = FWD_RF;

  // Without bypass paths the consumer waits until the producer has left WB.
  assign stall = id_valid && !flush &&
                 (reads_reg(ex_q.valid,  ex_q.regwrite,  ex_q.rd,  rs1_idx, rs2_idx, id_uses_rs2) ||
                  reads_reg(mem_q.valid, mem_q.regwrite, mem_q.rd, rs1_idx, rs2_idx, id_uses_rs2) ||
                  reads_reg(wb_q.valid,  wb_q.regwrite,  wb_q.rd,  rs1_idx, rs2_idx, id_uses_rs2));

  assign unused_ex_fields = &{1'b0, ex_q.rs1, ex_q.rs2, ex_q.uses_rs2, ex_q.memread};
`endif

  always_comb begin
    // NOTE: default first so every path assigns ex_d and no latch is inferred.
    ex_d = '0;
    if (id_valid && !flush && !stall) begin
      ex_d.valid    = 1'b1;
      ex_d.rd       = idx_t'(id_rd);
      ex_d.rs1      = rs1_idx;
      ex_d.rs2      = rs2_idx;
      ex_d.uses_rs2 = id_uses_rs2;
      ex_d.regwrite = id_regwrite;
      ex_d.memread  = id_memread;
    end
  end

  // NOTE: non-blocking assignments so every slot samples the previous cycle's state.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the slots are a handful of flops, not a RAM, so clearing them on reset is cheap.
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      stall_count <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= '{valid: ex_q.valid, rd: ex_q.rd, regwrite: ex_q.regwrite};
      wb_q  <= mem_q;
      if (stall && (stall_count != '1))
        stall_count <= stall_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed scoreboard bench for hazard_forward_unit; expectations follow HAZARD_FWD_EN.
module tb_hazard_forward_unit;

  localparam int CNT_W = 3;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             clk = 1'b0;
  logic             reset;
  logic             id_valid, id_regwrite, id_memread, id_uses_rs2, flush;
  logic [4:0]       id_rs1, id_rs2, id_rd;
  logic [1:0]       forwardA, forwardB;
  logic             stall;
  logic [CNT_W-1:0] stall_count;

  typedef struct {
    string            tag;
    logic [1:0]       fa;
    logic [1:0]       fb;
    logic             st;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t             sb[$];
  logic [CNT_W-1:0] exp_cnt;
  int               n_tests = 0;
  int               n_fail  = 0;

  hazard_forward_unit #(.REG_AW(5), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .id_uses_rs2(id_uses_rs2),
    .flush(flush), .forwardA(forwardA), .forwardB(forwardB),
    .stall(stall), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  task automatic check_front();
    exp_t e;
    e = sb.pop_front();
    n_tests++;
    assert (forwardA === e.fa) else begin
      n_fail++; $error("FAIL %s forwardA got %b exp %b", e.tag, forwardA, e.fa);
    end
    n_tests++;
    assert (forwardB === e.fb) else begin
      n_fail++; $error("FAIL %s forwardB got %b exp %b", e.tag, forwardB, e.fb);
    end
    n_tests++;
    assert (stall === e.st) else begin
      n_fail++; $error("FAIL %s stall got %b exp %b", e.tag, stall, e.st);
    end
    n_tests++;
    assert (stall_count === e.cnt) else begin
      n_fail++; $error("FAIL %s stall_count got %0d exp %0d", e.tag, stall_count, e.cnt);
    end
  endtask

  // One decode cycle: drive at the falling edge, check just after, model the counter.
  task automatic cyc(input string tag, input logic v, input logic [4:0] rd, rs1, rs2,
                     input logic rw, mr, u2, fl,
                     input logic [1:0] efa, efb, input logic est);
    @(negedge clk);
    id_valid = v; id_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
    id_regwrite = rw; id_memread = mr; id_uses_rs2 = u2; flush = fl;
    sb.push_back('{tag: tag, fa: efa, fb: efb, st: est, cnt: exp_cnt});
    #1 check_front();
    if (est && exp_cnt != CNT_MAX) exp_cnt = exp_cnt + 1'b1;
  endtask

  task automatic nop(input string tag, input logic [1:0] efa, efb);
    cyc(tag, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, efa, efb, 1'b0);
  endtask

  task automatic drain();
    repeat (3) nop("drain", 2'b00, 2'b00);
  endtask

  task automatic mid_reset();
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    exp_cnt = '0;
  endtask

  initial begin
    reset = 1'b1; exp_cnt = '0;
    id_valid = 0; id_rd = 0; id_rs1 = 0; id_rs2 = 0;
    id_regwrite = 0; id_memread = 0; id_uses_rs2 = 0; flush = 0;
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    nop("reset_state", 2'b00, 2'b00);

`ifdef HAZARD_FWD_EN
    // add x5 ; add x6,x5,x1 -> EX/MEM bypass, no stall
    cyc("mem_p", 1, 5, 1, 2, 1, 0, 1, 0, 2'b00, 2'b00, 0);
    cyc("mem_c", 1, 6, 5, 1, 1, 0, 1, 0, 2'b00, 2'b00, 0);
    nop("fwd_mem", 2'b10, 2'b00);
    nop("fwd_mem_d", 2'b00, 2'b00);
    drain();
    // add x5 ; nop ; sub x7,x2,x5 -> MEM/WB bypass on B
    cyc("wb_p", 1, 5, 1, 2, 1, 0, 1, 0, 2'b00, 2'b00, 0);
    nop("wb_n", 2'b00, 2'b00);
    cyc("wb_c", 1, 7, 2, 5, 1, 0, 1, 0, 2'b00, 2'b00, 0);
    nop("fwd_wb", 2'b00, 2'b01);
    drain();
    // two writers of x5: the younger one (MEM) wins
    cyc("pri_1", 1, 5, 1, 2, 1, 0, 1, 0, 2'b00, 2'b00, 0);
    cyc("pri_2", 1, 5, 3, 4, 1, 0, 1, 0, 2'b00, 2'b00, 0);
    cyc("pri_3", 1, 4, 5, 5, 1, 0, 1, 0, 2'b00, 2'b00, 0);
    nop("fwd_pri", 2'b10, 2'b10);
    drain();
    // immediate operand: rs2 field matches but must not forward
    cyc("imm_p", 1, 5, 1, 2, 1, 0, 1, 0, 2'b00, 2'b00, 0);
    nop("imm_n", 2'b00, 2'b00);
    cyc("imm_c", 1, 6, 5, 5, 1, 0, 0, 0, 2'b00, 2'b00, 0);
    nop("fwd_imm", 2'b01, 2'b00);
    drain();
    // ld x8 ; add x9,x8,x8 -> one stall, then WB bypass on both
    cyc("lu_ld", 1, 8, 1, 0, 1, 1, 0, 0, 2'b00, 2'b00, 0);
    cyc("lu_stall", 1, 9, 8, 8, 1, 0, 1, 0, 2'b00, 2'b00, 1);
    cyc("lu_hold", 1, 9, 8, 8, 1, 0, 1, 0, 2'b00, 2'b00, 0);
    nop("lu_fwd", 2'b01, 2'b01);
    drain();
    // x0 is never a dependency
    cyc("x0_p", 1, 0, 1, 2, 1, 0, 1, 0, 2'b00, 2'b00, 0);
    cyc("x0_c", 1, 1, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 0);
    nop("x0_fwd", 2'b00, 2'b00);
    drain();
    cyc("x0_ld", 1, 0, 1, 0, 1, 1, 0, 0, 2'b00, 2'b00, 0);
    cyc("x0_lu", 1, 9, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 0);
    nop("x0_lu_n", 2'b00, 2'b00);
    drain();
    // load-use under flush: no stall, consumer killed
    cyc("fl_ld", 1, 8, 1, 0, 1, 1, 0, 0, 2'b00, 2'b00, 0);
    cyc("fl_lu", 1, 9, 8, 8, 1, 0, 1, 1, 2'b00, 2'b00, 0);
    nop("fl_bubble", 2'b00, 2'b00);
    drain();
    cyc("nv_ld", 1, 8, 1, 0, 1, 1, 0, 0, 2'b00, 2'b00, 0);
    cyc("nv_gate", 0, 9, 8, 8, 1, 0, 1, 0, 2'b00, 2'b00, 0);
    drain();
    // counter saturation
    for (int i = 0; i < 7; i++) begin
      cyc("sat_ld", 1, 8, 1, 0, 1, 1, 0, 0, 2'b00, 2'b00, 0);
      cyc("sat_lu", 1, 9, 8, 8, 1, 0, 1, 0, 2'b00, 2'b00, 1);
      cyc("sat_hold", 1, 9, 8, 8, 1, 0, 1, 0, 2'b00, 2'b00, 0);
      nop("sat_fwd", 2'b01, 2'b01);
    end
    drain();
    // reset in the middle of a stall
    cyc("rs_ld", 1, 8, 1, 0, 1, 1, 0, 0, 2'b00, 2'b00, 0);
    cyc("rs_stall", 1, 9, 8, 8, 1, 0, 1, 0, 2'b00, 2'b00, 1);
    mid_reset();
    cyc("rs_clear", 1, 9, 8, 8, 1, 0, 1, 0, 2'b00, 2'b00, 0);
    nop("rs_after", 2'b00, 2'b00);
    drain();
`else
    // add x5 ; add x6,x5,x1 -> three interlock cycles, no forwarding
    cyc("st_p", 1, 5, 1, 2, 1, 0, 1, 0, 2'b00, 2'b00, 0);
    cyc("st_ex", 1, 6, 5, 1, 1, 0, 1, 0, 2'b00, 2'b00, 1);
    cyc("st_mem", 1, 6, 5, 1, 1, 0, 1, 0, 2'b00, 2'b00, 1);
    cyc("st_wb", 1, 6, 5, 1, 1, 0, 1, 0, 2'b00, 2'b00, 1);
    cyc("st_go", 1, 6, 5, 1, 1, 0, 1, 0, 2'b00, 2'b00, 0);
    nop("st_nofwd", 2'b00, 2'b00);
    drain();
    // rs2 only counts when it is a real operand
    cyc("u2_p", 1, 5, 1, 2, 1, 0, 1, 0, 2'b00, 2'b00, 0);
    cyc("u2_imm", 1, 6, 1, 5, 1, 0, 0, 0, 2'b00, 2'b00, 0);
    cyc("u2_mem", 1, 7, 1, 5, 1, 0, 1, 0, 2'b00, 2'b00, 1);
    cyc("u2_wb", 1, 7, 1, 5, 1, 0, 1, 0, 2'b00, 2'b00, 1);
    cyc("u2_go", 1, 7, 1, 5, 1, 0, 1, 0, 2'b00, 2'b00, 0);
    nop("u2_n", 2'b00, 2'b00);
    drain();
    // x0 is never a dependency
    cyc("x0_p", 1, 0, 1, 2, 1, 0, 1, 0, 2'b00, 2'b00, 0);
    cyc("x0_c", 1, 1, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 0);
    nop("x0_n", 2'b00, 2'b00);
    drain();
    // flush and an empty decode slot both suppress the interlock
    cyc("fl_p", 1, 5, 1, 2, 1, 0, 1, 0, 2'b00, 2'b00, 0);
    cyc("fl_gate", 1, 9, 5, 1, 1, 0, 1, 1, 2'b00, 2'b00, 0);
    cyc("nv_gate", 0, 9, 5, 1, 1, 0, 1, 0, 2'b00, 2'b00, 0);
    drain();
    // counter saturation
    for (int i = 0; i < 2; i++) begin
      cyc("sat_p", 1, 5, 1, 2, 1, 0, 1, 0, 2'b00, 2'b00, 0);
      repeat (3) cyc("sat_st", 1, 6, 5, 1, 1, 0, 1, 0, 2'b00, 2'b00, 1);
      cyc("sat_go", 1, 6, 5, 1, 1, 0, 1, 0, 2'b00, 2'b00, 0);
      nop("sat_n", 2'b00, 2'b00);
      drain();
    end
    // reset in the middle of a stall
    cyc("rs_p", 1, 5, 1, 2, 1, 0, 1, 0, 2'b00, 2'b00, 0);
    cyc("rs_stall", 1, 6, 5, 1, 1, 0, 1, 0, 2'b00, 2'b00, 1);
    mid_reset();
    cyc("rs_clear", 1, 6, 5, 1, 1, 0, 1, 0, 2'b00, 2'b00, 0);
    nop("rs_after", 2'b00, 2'b00);
    drain();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_forward_unit.md
HAZARD_FORWARD_UNIT -- requirements
Module: hazard_forward_unit

Interface
REQ-001 SHALL have parameter REG_AW, default 5, register-index width.
REQ-002 SHALL have parameter CNT_W, default 32, stall-counter width.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port id_valid  input  1  decode slot holds a real instruction.
REQ-006 SHALL have ports id_rs1, id_rs2, id_rd  input  REG_AW  decode source and destination indices.
REQ-007 SHALL have port id_regwrite  input  1  decode instruction writes rd.
REQ-008 SHALL have port id_memread  input  1  decode instruction is a load.
REQ-009 SHALL have port id_uses_rs2  input  1  rs2 is a real operand, not an immediate (Alusrc=0 or store).
REQ-010 SHALL have port flush  input  1  taken branch in EX; wrong-path decode slot is killed.
REQ-011 SHALL have port forwardA  output  2  execute operand-A select: 00 register file, 01 MEM/WB write_data, 10 EX/MEM result.
REQ-012 SHALL have port forwardB  output  2  execute operand-B select, same encoding.
REQ-013 SHALL have port stall  output  1  hold PC and IF/ID, insert bubble into EX.
REQ-014 SHALL have port stall_count  output  CNT_W  total stall cycles since reset.

Function
REQ-015 SHALL keep shadow slots EX{valid,rd,rs1,rs2,uses_rs2,regwrite,memread}, MEM{valid,rd,regwrite}, WB{valid,rd,regwrite}.
REQ-016 SHALL advance each cycle: WB<=MEM, MEM<=EX, EX<=decode fields, or a bubble (valid=0) when stall, flush or !id_valid.
REQ-017 SHALL drive forwardA=10 when MEM.valid & MEM.regwrite & MEM.rd!=0 & MEM.rd==EX.rs1; else 01 when the same holds for WB; else 00.
REQ-018 SHALL compute forwardB identically against EX.rs2, and force it to 00 when !EX.uses_rs2.
REQ-019 SHALL give MEM priority over WB when both match the same source.
REQ-020 SHALL never forward or stall on register index 0.
REQ-021 SHALL assert stall, combinationally in the same cycle, when id_valid & !flush & EX.valid & EX.memread & EX.rd!=0 & (EX.rd==id_rs1 | (id_uses_rs2 & EX.rd==id_rs2)) (load-use, 1 cycle).
REQ-022 SHALL let flush win over stall in the same cycle: stall=0, EX receives a bubble.
REQ-023 SHALL increment stall_count on every cycle stall=1 and saturate at all-ones.

Reset
REQ-024 SHALL clear every slot valid bit, all slot fields and stall_count to 0 on a clk edge with reset=1; forwardA=forwardB=00 and stall=0 the following cycle.
REQ-025 SHALL let reset override stall and flush, including mid-stall.

Configuration
REQ-026 SHALL support macro HAZARD_FWD_EN: when defined, REQ-017..REQ-021 apply.
REQ-027 SHALL, without HAZARD_FWD_EN, tie forwardA=forwardB=00 and assert stall while any valid, regwrite, rd!=0 slot in EX, MEM or WB matches id_rs1, or matches id_rs2 with id_uses_rs2, gated by id_valid & !flush (up to 3 stall cycles).

Structure
REQ-028 SHALL take the forward-select encodings (FWD_RF, FWD_WB, FWD_MEM) and the slot struct typedef from the shared core package.
REQ-029 SHALL instantiate a single sub-module fwd_compare, used twice, which maps one source index plus MEM/WB slot state to a 2-bit select.

Verification
REQ-030 SHALL check: add x5 then add x6,x5,x1 back-to-back -> forwardA=10 in the consumer's EX cycle, stall never asserted.
REQ-031 SHALL check: add x5; nop; sub x7,x2,x5 -> forwardB=01 in sub's EX cycle.
REQ-032 SHALL check: ld x8 then add x9,x8,x8 -> stall=1 for exactly 1 cycle, then forwardA=forwardB=01, stall_count=1.
REQ-033 SHALL check: writer to x0 followed by a reader of x0 -> forwardA=00, stall=0.
REQ-034 SHALL check: load-use hazard with flush=1 in the same cycle -> stall=0, EX bubble, stall_count unchanged.
REQ-035 SHALL check: without HAZARD_FWD_EN, add x5 then reader of x5 -> stall for 3 cycles, forwardA stays 00; reset asserted mid-stall clears stall the next cycle.
